hazard_ctrl: RTL and testbench

- Sequential hazard controller for the 5-stage pipeline; sits beside the decode stage.
- Tracks destination registers of in-flight instructions in a shift-register scoreboard (ID/EX, EX/MEM, MEM/WB).
- Compares the decode instruction's sources against the scoreboard and drives stall/bubble for RAW hazards.
- Also sequences HALT drain and counts hazard stalls.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/inst_reg_decode.sv | 40 ++++
 rtl/hazard_ctrl.sv | 69 ++++++
 tb/tb_hazard_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode constants, scoreboard entry type, FSM states and source-match helper
// shared by the hazard controller and its instruction decoder.
package hazard_pkg;
    localparam logic [4:0] OP_HALT     = 5'b00000;
    localparam logic [4:0] OP_LD       = 5'b10001;
    localparam logic [4:0] OP_ST       = 5'b10000;
    localparam logic [4:0] OP_STU      = 5'b10011;
    localparam logic [4:0] OP_LBI      = 5'b11000;
    localparam logic [4:0] OP_SLBI     = 5'b10010;
    localparam logic [4:0] OP_JAL_JALR = 5'b00110;
    localparam logic [2:0] REG_LINK    = 3'd7;

    typedef struct packed {
        logic       vld;
        logic [2:0] dest;
        logic       is_ld;
    } sb_entry_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    function automatic logic src_hit(input sb_entry_t e, input logic [2:0] src1, input logic [2:0] src2,
                                     input logic use1, input logic use2);
        return e.vld && ((use1 && e.dest == src1) || (use2 && e.dest == src2));
    endfunction
endpackage

// File: rtl/inst_reg_decode.sv
// inst_reg_decode: combinational extraction of source/destination registers from a
// 16-bit instruction for hazard detection.
module inst_reg_decode
    import hazard_pkg::*;
(
    input  logic [15:0] inst,
    output logic [2:0]  src1,
    output logic [2:0]  src2,
    output logic        use1,
    output logic        use2,
    output logic [2:0]  dest,
    output logic        has_dest,
    output logic        is_ld,
    output logic        is_halt
);
    logic [4:0] op;
    logic r_fmt, imm, st, stu, lbi, slbi, jal, jr, br;

    assign op    = inst[15:11];
    assign r_fmt = (op[4:1] == 4'b1101) || (op[4:2] == 3'b111) || (op == 5'b11001);
    assign imm   = (op[4:2] == 3'b010) || (op[4:2] == 3'b101);
    assign st    = op == OP_ST;
    assign stu   = op == OP_STU;
    assign lbi   = op == OP_LBI;
    assign slbi  = op == OP_SLBI;
    assign jal   = op[4:1] == OP_JAL_JALR[4:1];
    assign jr    = (op[4:2] == 3'b001) && op[0];
    assign br    = op[4:2] == 3'b011;

    assign is_ld    = op == OP_LD;
    assign is_halt  = op == OP_HALT;
    assign src1     = inst[10:8];
    assign src2     = inst[7:5];
    assign use1     = r_fmt || imm || is_ld || slbi || jr || br || st || stu;
    assign use2     = r_fmt || st || stu;
    assign has_dest = r_fmt || imm || is_ld || stu || lbi || slbi || jal;
    assign dest     = r_fmt ? inst[4:2] :
                      (imm || is_ld) ? inst[7:5] :
                      (stu || lbi || slbi) ? inst[10:8] : REG_LINK;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW scoreboard, HALT drain FSM and saturating stall counter.
// Define HAZARD_CTRL_FORWARD_EN to assume EX/MEM forwarding (only load-use stalls).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_inst,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    sb_entry_t  sb [SB_DEPTH];
    sb_entry_t  sb_in;
    state_t     state, state_nxt;
    logic [2:0] src1, src2, dest;
    logic       use1, use2, has_dest, is_ld, is_halt;
    logic       match, sb_empty, hz, hz_stall;

    inst_reg_decode u_dec (
        .inst(id_inst), .src1(src1), .src2(src2), .use1(use1), .use2(use2),
        .dest(dest), .has_dest(has_dest), .is_ld(is_ld), .is_halt(is_halt)
    );

    always_comb begin
        sb_empty = 1'b1;
        match    = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            sb_empty = sb_empty && !sb[i].vld;
`ifdef HAZARD_CTRL_FORWARD_EN
            if (i == 0) match = sb[0].is_ld && src_hit(sb[0], src1, src2, use1, use2);
`else
            match = match || src_hit(sb[i], src1, src2, use1, use2);
`endif
        end
    end

    assign hz       = id_valid && match;
    assign hz_stall = state == RUN && hz && !flush;

    always_comb begin
        stall     = hz_stall || state != RUN;
        bubble    = stall || flush;
        halted    = state == HALTED;
        sb_in     = bubble ? '0 : {id_valid && has_dest, dest, is_ld};
        state_nxt = state;
        if (state == RUN && id_valid && is_halt && !stall && !flush) state_nxt = DRAIN;
        else if (state == DRAIN) state_nxt = flush ? RUN : sb_empty ? HALTED : DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
        end else begin
            state <= state_nxt;
            sb[0] <= sb_in;
            for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
            if (hz_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table-driven bench for hazard_ctrl (CNT_W=4) plus
// hand-written HALT drain, flush, saturation and async-reset sequences.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] id_inst = '0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;
    logic        stall, bubble, halted;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.SB_DEPTH(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
        .stall(stall), .bubble(bubble), .halted(halted), .stall_cnt(stall_cnt)
    );

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam int RAW = 0;
    localparam int LDS = 1;
`else
    localparam int RAW = 3;
    localparam int LDS = 3;
`endif

    localparam logic [15:0] ADDI1 = 16'h4025, ADDI2 = 16'h4045, ADDI3 = 16'h4065;
    localparam logic [15:0] ADD   = 16'hD928, LD = 16'h8820, HALT = 16'h0000;

    typedef struct {
        logic [15:0] inst;
        logic        valid;
        logic        fl;
        logic        st;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] i, input logic v, input logic f, input logic s);
        vec_t e;
        e.inst = i; e.valid = v; e.fl = f; e.st = s;
        tv.push_back(e);
    endtask

    // Drive one cycle, compare at the negedge, advance past the posedge.
    // inc: this cycle is a RUN-state hazard stall that the counter must record.
    task automatic apply(input string nm, input logic [15:0] i, input logic v, input logic f,
                         input logic s, input logic h, input logic inc);
        id_inst = i; id_valid = v; flush = f;
        @(negedge clk);
        chk({nm, "_stall"}, int'(stall), int'(s));
        chk({nm, "_bubble"}, int'(bubble), int'(s | f));
        chk({nm, "_halted"}, int'(halted), int'(h));
        chk({nm, "_cnt"}, int'(stall_cnt), mcnt);
        if (inc && mcnt < 15) mcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string nm);
        rst_n = 1'b0;
        #1;
        chk({nm, "_stall"}, int'(stall), 0);
        chk({nm, "_bubble"}, int'(bubble), 0);
        chk({nm, "_halted"}, int'(halted), 0);
        chk({nm, "_cnt"}, int'(stall_cnt), 0);
        mcnt = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset_stall", int'(stall), 0);
        chk("reset_bubble", int'(bubble), 0);
        chk("reset_halted", int'(halted), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back ADDI r1 -> ADD r2,r1,r1
        add(ADDI1, 1, 0, 0);
        for (int k = 0; k < RAW; k++) add(ADD, 1, 0, 1);
        add(ADD, 1, 0, 0);
        repeat (3) add(16'h0, 0, 0, 0);
        // Load-use
        add(LD, 1, 0, 0);
        for (int k = 0; k < LDS; k++) add(ADD, 1, 0, 1);
        add(ADD, 1, 0, 0);
        repeat (3) add(16'h0, 0, 0, 0);
        // Independent stream
        add(ADDI1, 1, 0, 0);
        add(ADDI2, 1, 0, 0);
        add(ADDI3, 1, 0, 0);
        repeat (3) add(16'h0, 0, 0, 0);
        // Flush coincident with a hazard: the wrong-path ADD is squashed
        add(ADDI1, 1, 0, 0);
        add(ADD, 1, 1, 0);
        for (int k = 0; k < (RAW > 0 ? RAW - 1 : 0); k++) add(ADD, 1, 0, 1);
        add(ADD, 1, 0, 0);
        repeat (3) add(16'h0, 0, 0, 0);

        foreach (tv[n]) apply($sformatf("vec%0d", n), tv[n].inst, tv[n].valid, tv[n].fl, tv[n].st, 1'b0, tv[n].st);
        chk("table_cnt_total", int'(stall_cnt), (RAW + LDS + (RAW > 0 ? RAW - 1 : 0)) > 15 ? 15 : RAW + LDS + (RAW > 0 ? RAW - 1 : 0));

        // HALT with three valid entries in flight
        apply("fill1", ADDI1, 1, 0, 0, 0, 0);
        apply("fill2", ADDI2, 1, 0, 0, 0, 0);
        apply("fill3", ADDI3, 1, 0, 0, 0, 0);
        apply("halt_accept", HALT, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) apply($sformatf("drain%0d", k), ADDI1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) apply($sformatf("halted%0d", k), ADDI1, 1, 0, 1, 1, 0);
        async_reset("rst_halted");

        // Flush during DRAIN returns to RUN
        apply("pre_halt2", ADDI1, 1, 0, 0, 0, 0);
        apply("halt2", HALT, 1, 0, 0, 0, 0);
        apply("drain_flush", 16'h0, 0, 1, 1, 0, 0);
        apply("after_flush0", 16'h0, 0, 0, 0, 0, 0);
        apply("after_flush1", 16'h0, 0, 0, 0, 0, 0);

        // Saturation of the 4-bit counter
        for (int p = 0; p < 20; p++) begin
            apply("sat_ld", LD, 1, 0, 0, 0, 0);
            for (int k = 0; k < LDS; k++) apply("sat_stall", ADD, 1, 0, 1, 0, 1);
            apply("sat_go", ADD, 1, 0, 0, 0, 0);
        end
        chk("sat_hold", int'(stall_cnt), 15);

        // Async reset in the middle of a stall
        apply("mid_ld", LD, 1, 0, 0, 0, 0);
        id_inst = ADD; id_valid = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("mid_pre_stall", int'(stall), 1);
        async_reset("mid_rst");
        apply("post_rst_empty", ADD, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
